// File: rtl/laser500_prg_loader.sv
// Laser 500 PRG/BIN download loader: streams HPS file bytes into CPU RAM
// through a 4-deep write FIFO and patches the BASIC end pointer after PRGs.
module laser500_prg_loader #(
    parameter logic [15:0] BIN_BASE = 16'h8995,
    parameter logic [15:0] END_PTR  = 16'h83E9
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_wr,
    input  logic        ram_ack,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_HDR_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_PTR_LO = 3'd5;
    localparam logic [2:0] S_PTR_HI = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic        dl_q;
    logic        prg_q, prg_d;
    logic [15:0] ptr_q, ptr_d;
    logic [24:0] exp_q, exp_d;
    logic        err_q, err_d;
    logic [15:0] fa_q [4];
    logic [7:0]  fd_q [4];
    logic [1:0]  wp_q, rp_q;
    logic [2:0]  cnt_q, cnt_d;
    logic        push, pop, in_ptr, rise;

    assign rise       = ioctl_download && !dl_q;
    assign in_ptr     = (state_q == S_PTR_LO) || (state_q == S_PTR_HI);
    assign ioctl_wait = (cnt_q >= 3'd3) || (state_q == S_DRAIN) || in_ptr;
    assign ram_wr     = (cnt_q != 3'd0) || in_ptr;
    assign pop        = ram_ack && (cnt_q != 3'd0);
    assign cpu_hold   = (state_q != S_IDLE);
    assign load_done  = (state_q == S_DONE);
    assign load_err   = err_q;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        unique case (1'b1)
            state_q == S_PTR_LO: begin
                ram_addr = END_PTR;
                ram_din  = ptr_q[7:0];
            end
            state_q == S_PTR_HI: begin
                ram_addr = END_PTR + 16'd1;
                ram_din  = ptr_q[15:8];
            end
            cnt_q != 3'd0: begin
                ram_addr = fa_q[rp_q];
                ram_din  = fd_q[rp_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        prg_d   = prg_q;
        ptr_d   = ptr_q;
        exp_d   = exp_q;
        err_d   = err_q;
        push    = 1'b0;
        // Every accepted byte, header included, is checked against its offset
        if (ioctl_wr && !ioctl_wait &&
            (state_q == S_HDR_LO || state_q == S_HDR_HI || state_q == S_DATA)) begin
            exp_d = exp_q + 25'd1;
            if (ioctl_addr != exp_q) err_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (rise && ioctl_index == 8'd1) begin
                    state_d = S_HDR_LO;
                    prg_d   = 1'b1;
                    exp_d   = '0;
                    err_d   = 1'b0;
                end else if (rise && ioctl_index == 8'd2) begin
                    state_d = S_DATA;
                    prg_d   = 1'b0;
                    ptr_d   = BIN_BASE;
                    exp_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_HDR_LO: begin
                if (!ioctl_download) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (ioctl_wr) begin
                    ptr_d[7:0] = ioctl_data;
                    state_d    = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (!ioctl_download) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (ioctl_wr) begin
                    ptr_d[15:8] = ioctl_data;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (ioctl_wr && !ioctl_wait) begin
                    push  = 1'b1;
                    ptr_d = ptr_q + 16'd1;
                end
                if (!ioctl_download) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == 3'd0) state_d = prg_q ? S_PTR_LO : S_DONE;
            end
            S_PTR_LO: if (ram_ack) state_d = S_PTR_HI;
            S_PTR_HI: if (ram_ack) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // dl_q resets high so a download already active at release is not a start
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b1;
            prg_q   <= 1'b0;
            ptr_q   <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            prg_q   <= prg_d;
            ptr_q   <= ptr_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (push) wp_q <= wp_q + 2'd1;
            if (pop)  rp_q <= rp_q + 2'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fa_q[wp_q] <= ptr_q;
            fd_q[wp_q] <= ioctl_data;
        end
    end

endmodule

// File: tb/tb_laser500_prg_loader.sv
// Self-checking bench for laser500_prg_loader: vector table, directed
// corner sequences and randomized downloads against a file-level model.
module tb_laser500_prg_loader;

    localparam logic [15:0] BIN_BASE = 16'h8995;
    localparam logic [15:0] END_PTR  = 16'h83E9;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic        ram_ack;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    laser500_prg_loader dut (
        .clk_sys        (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_wr         (ram_wr),
        .ram_ack        (ram_ack),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int stall = 0;
    logic ack_hold = 1'b0;
    logic m_err = 1'b0;
    int done_cnt = 0;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    logic [15:0] ea[$];
    logic [7:0]  ed[$];

    // Memory arbiter stand-in: acks one cycle after ram_wr, optionally stalled
    initial begin
        ram_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ram_ack) ram_ack = 1'b0;
            else if (ram_wr && !ack_hold &&
                     int'($urandom_range(99)) >= stall) ram_ack = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (ram_wr && ram_ack) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_din);
        end
        if (load_done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timeout, got no response, want progress", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        int g = 0;
        while (ioctl_wait && g < 300) begin
            tick();
            g++;
        end
        if (g >= 300) timeout("wait_release");
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_data = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic end_dl();
        int g = 0;
        ioctl_download = 1'b0;
        tick();
        while (cpu_hold && g < 1000) begin
            tick();
            g++;
        end
        if (g >= 1000) timeout("load_finish");
        tick();
    endtask

    task automatic run_file(input logic [7:0] idx, input logic [7:0] b[$],
                            input int bad, output int base, output int dbase);
        base  = wa.size();
        dbase = done_cnt;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < b.size(); i++) begin
            repeat ($urandom_range(2)) tick();
            send_byte((i == bad) ? (i ^ 1) : i, b[i]);
        end
        end_dl();
    endtask

    // File-level reference: what RAM should see for a whole download
    task automatic model(input logic [7:0] idx, input logic [7:0] b[$],
                         input int bad, output int md);
        logic [15:0] p;
        ea.delete();
        ed.delete();
        md = 0;
        if (idx == 8'd1 || idx == 8'd2) begin
            m_err = 1'b0;
            if (bad >= 0 && bad < b.size()) m_err = 1'b1;
        end
        if (idx == 8'd2) begin
            for (int i = 0; i < b.size(); i++) begin
                ea.push_back(BIN_BASE + 16'(i));
                ed.push_back(b[i]);
            end
            md = 1;
        end else if (idx == 8'd1) begin
            if (b.size() < 2) m_err = 1'b1;
            else begin
                p = {b[1], b[0]};
                for (int i = 2; i < b.size(); i++) begin
                    ea.push_back(p);
                    ed.push_back(b[i]);
                    p = p + 16'd1;
                end
                ea.push_back(END_PTR);
                ed.push_back(p[7:0]);
                ea.push_back(END_PTR + 16'd1);
                ed.push_back(p[15:8]);
                md = 1;
            end
        end
    endtask

    task automatic compare(input string nm, input int base, input int dbase,
                           input int md);
        int n = wa.size() - base;
        chk({nm, "_nwr"}, 32'(n), 32'(ea.size()));
        for (int i = 0; i < n && i < ea.size(); i++) begin
            chk({nm, "_addr"}, 32'(wa[base+i]), 32'(ea[i]));
            chk({nm, "_data"}, 32'(wd[base+i]), 32'(ed[i]));
        end
        chk({nm, "_done"}, 32'(done_cnt - dbase), 32'(md));
        chk({nm, "_err"}, 32'(load_err), 32'(m_err));
        chk({nm, "_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  idx;
        int          len;
        logic [47:0] b;
        int          nwr;
        logic [15:0] fa;
        logic [7:0]  fd;
        logic [15:0] la;
        logic [7:0]  ld;
        logic        err;
        int          done;
    } vec_t;

    vec_t tv[7];

    initial begin
        int base, dbase, md, n;
        logic [7:0] q[$];

        tv[0] = '{idx:8'd1, len:5, b:48'h00CCBBAA1234, nwr:5, fa:16'h1234,
                  fd:8'hAA, la:16'h83EA, ld:8'h12, err:1'b0, done:1};
        tv[1] = '{idx:8'd2, len:3, b:48'h000000030201, nwr:3, fa:16'h8995,
                  fd:8'h01, la:16'h8997, ld:8'h03, err:1'b0, done:1};
        tv[2] = '{idx:8'd1, len:5, b:48'h00332211FFFE, nwr:5, fa:16'hFFFE,
                  fd:8'h11, la:16'h83EA, ld:8'h00, err:1'b0, done:1};
        tv[3] = '{idx:8'd1, len:1, b:48'h000000000055, nwr:0, fa:16'h0,
                  fd:8'h0, la:16'h0, ld:8'h0, err:1'b1, done:0};
        tv[4] = '{idx:8'd1, len:3, b:48'h000000779000, nwr:3, fa:16'h9000,
                  fd:8'h77, la:16'h83EA, ld:8'h90, err:1'b0, done:1};
        tv[5] = '{idx:8'd3, len:2, b:48'h000000000201, nwr:0, fa:16'h0,
                  fd:8'h0, la:16'h0, ld:8'h0, err:1'b0, done:0};
        tv[6] = '{idx:8'd1, len:2, b:48'h000000004000, nwr:2, fa:16'h83E9,
                  fd:8'h00, la:16'h83EA, ld:8'h40, err:1'b0, done:1};

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        repeat (3) tick();
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        for (int r = 0; r < 7; r++) begin
            q.delete();
            for (int i = 0; i < tv[r].len; i++) q.push_back(tv[r].b[8*i +: 8]);
            run_file(tv[r].idx, q, -1, base, dbase);
            n = wa.size() - base;
            chk($sformatf("tv%0d_nwr", r), 32'(n), 32'(tv[r].nwr));
            if (tv[r].nwr > 0 && n > 0) begin
                chk($sformatf("tv%0d_first_a", r), 32'(wa[base]), 32'(tv[r].fa));
                chk($sformatf("tv%0d_first_d", r), 32'(wd[base]), 32'(tv[r].fd));
                chk($sformatf("tv%0d_last_a", r), 32'(wa[wa.size()-1]), 32'(tv[r].la));
                chk($sformatf("tv%0d_last_d", r), 32'(wd[wd.size()-1]), 32'(tv[r].ld));
            end
            chk($sformatf("tv%0d_err", r), 32'(load_err), 32'(tv[r].err));
            chk($sformatf("tv%0d_done", r), 32'(done_cnt - dbase), 32'(tv[r].done));
            model(tv[r].idx, q, -1, md);
            compare($sformatf("tv%0d", r), base, dbase, md);
        end

        // Backpressure: ack withheld while bytes stream in
        base  = wa.size();
        dbase = done_cnt;
        ack_hold       = 1'b1;
        ioctl_index    = 8'd2;
        ioctl_download = 1'b1;
        tick();
        send_byte(0, 8'hA0);
        chk("bp_latency_wr", 32'(ram_wr), 32'd1);
        chk("bp_head_addr", 32'(ram_addr), 32'(BIN_BASE));
        chk("bp_head_din", 32'(ram_din), 32'hA0);
        send_byte(1, 8'hA1);
        chk("bp_wait_at2", 32'(ioctl_wait), 32'd0);
        send_byte(2, 8'hA2);
        chk("bp_wait_at3", 32'(ioctl_wait), 32'd1);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd3;
        ioctl_data = 8'hEE;
        tick();
        ioctl_wr = 1'b0;
        repeat (17) tick();
        chk("bp_wait_held", 32'(ioctl_wait), 32'd1);
        chk("bp_head_held", 32'(ram_addr), 32'(BIN_BASE));
        ack_hold = 1'b0;
        send_byte(3, 8'hA3);
        send_byte(4, 8'hA4);
        send_byte(5, 8'hA5);
        end_dl();
        q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        model(8'd2, q, -1, md);
        compare("bp", base, dbase, md);

        for (int t = 0; t < 25; t++) begin
            int r, len, bad;
            logic [7:0] idx;
            r   = int'($urandom_range(9));
            idx = (r < 5) ? 8'd1 : (r < 9) ? 8'd2 : 8'd3;
            len = int'($urandom_range(10));
            bad = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
            stall = int'($urandom_range(70));
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_file(idx, q, bad, base, dbase);
            model(idx, q, bad, md);
            compare($sformatf("rnd%0d", t), base, dbase, md);
        end
        stall = 0;

        // Reset with two entries pending, download still high at release
        base     = wa.size();
        ack_hold = 1'b1;
        ioctl_index    = 8'd2;
        ioctl_download = 1'b1;
        tick();
        send_byte(0, 8'h11);
        send_byte(1, 8'h22);
        chk("mid_rst_pending", 32'(ram_wr), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(ram_wr), 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_addr", 32'(ram_addr), 32'd0);
        tick();
        tick();
        reset_n  = 1'b1;
        ack_hold = 1'b0;
        repeat (10) tick();
        chk("post_rst_nwr", 32'(wa.size() - base), 32'd0);
        chk("post_rst_hold", 32'(cpu_hold), 32'd0);
        ioctl_download = 1'b0;
        repeat (2) tick();
        m_err = 1'b0;

        q = {8'h00, 8'hC0, 8'h5A, 8'hA5};
        run_file(8'd1, q, -1, base, dbase);
        model(8'd1, q, -1, md);
        compare("recover", base, dbase, md);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
